// File: rtl/mips_avalon_arb_pkg.sv
// Shared types and constants for the MIPS instruction/data Avalon arbiter.
package mips_avalon_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUS_I,
        ARB_BUS_D
    } arb_state_t;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } arb_port_t;

    // An instruction fetch always transfers a full word.
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_avalon_arb_rr.sv
// Two-way round-robin picker. On a tie it grants the port that did not win
// last time. With a single requester, that requester is granted.
module mips_avalon_arb_rr
    import mips_avalon_arb_pkg::*;
(
    input  logic      instr_req,
    input  logic      data_req,
    input  arb_port_t last_grant,
    output logic      grant_valid,
    output arb_port_t grant
);

    // Pick the winner from the current requests and the previous winner.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_valid = instr_req | data_req;
        grant       = PORT_INSTR;
        if (instr_req && data_req) begin
            grant = (last_grant == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else if (data_req) begin
            grant = PORT_DATA;
        end
    end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon-MM master between the CPU fetch port and data port.
// The winning request is latched into registered avm_* signals and held
// across waitrequest. Completion returns read data with a one-cycle done
// pulse. Protocol errors and bus timeouts set a sticky error flag.
module mips_avalon_arbiter
    import mips_avalon_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_done,
    // data port
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_done,
    // Avalon-MM master
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    // status
    output logic        error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    arb_port_t        last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic      instr_req;
    logic      data_req;
    logic      grant_valid;
    arb_port_t grant;

    // A port whose done pulse is high is finishing; its still-high request
    // is the old one and must not be re-granted at this edge.
    assign instr_req = instr_read & ~instr_done;
    assign data_req  = (data_read | data_write) & ~data_done;

    mips_avalon_arb_rr u_rr (
        .instr_req  (instr_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    // Arbitration FSM with registered bus, completion and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB_IDLE;
            last_grant     <= PORT_DATA;
            wait_cnt       <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            instr_done     <= 1'b0;
            data_done      <= 1'b0;
            // NOTE: the readdata holding registers are cleared too, because
            // they are visible outputs and must read 0 after reset.
            instr_readdata <= '0;
            data_readdata  <= '0;
            error          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other one.
            instr_done <= 1'b0;
            data_done  <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        wait_cnt   <= '0;
                        last_grant <= grant;
                        if (grant == PORT_INSTR) begin
                            avm_address    <= instr_address;
                            avm_read       <= 1'b1;
                            avm_write      <= 1'b0;
                            avm_writedata  <= '0;
                            avm_byteenable <= BE_WORD;
                            state          <= ARB_BUS_I;
                        end else begin
                            // A simultaneous read and write is illegal;
                            // the write is carried out and flagged.
                            avm_address    <= data_address;
                            avm_read       <= data_read & ~data_write;
                            avm_write      <= data_write;
                            avm_writedata  <= data_writedata;
                            avm_byteenable <= data_byteenable;
                            if (data_read && data_write) begin
                                error <= 1'b1;
                            end
                            state <= ARB_BUS_D;
                        end
                    end
                end

                ARB_BUS_I, ARB_BUS_D: begin
                    if (avm_waitrequest) begin
                        // Saturate so a stuck slave cannot wrap the counter.
                        if (wait_cnt != CNT_LIMIT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt == CNT_LAST) begin
                            error <= 1'b1;
                        end
                    end else begin
                        if (state == ARB_BUS_I) begin
                            instr_readdata <= avm_readdata;
                            instr_done     <= 1'b1;
                        end else begin
                            if (avm_read) begin
                                data_readdata <= avm_readdata;
                            end
                            data_done <= 1'b1;
                        end
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        state     <= ARB_IDLE;
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed self-checking bench for mips_avalon_arbiter with a small
// Avalon slave model whose wait states are programmable.
module tb_mips_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_done;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        error;

    int checks = 0;
    int errors = 0;

    // slave model controls
    int   wait_cycles = 0;   // wait states inserted per transfer
    logic force_wait  = 1'b0;
    int   wcnt;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mips_avalon_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_read     (instr_read),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .instr_done     (instr_done),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_byteenable(data_byteenable),
        .data_readdata  (data_readdata),
        .data_done      (data_done),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .error          (error)
    );

    // Slave: word memory indexed by address[9:2], wait_cycles stalls per access.
    assign avm_waitrequest = force_wait || ((avm_read || avm_write) && (wcnt < wait_cycles));
    assign avm_readdata    = mem[avm_address[9:2]];

    always @(posedge clk) begin
        if (reset) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h3C01_1234;   // 0xBFC00000
            mem[1] <= 32'h2222_3333;   // 0xBFC00004
            mem[8] <= 32'h1111_2222;   // 0x00000020
        end else begin
            if (!(avm_read || avm_write) || !avm_waitrequest) wcnt <= 0;
            else wcnt <= wcnt + 1;
            if (avm_write && !avm_waitrequest) begin
                for (int b = 0; b < 4; b++)
                    if (avm_byteenable[b]) mem[avm_address[9:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Fetch from addr; call right after a negedge. Returns avm_read cycles seen.
    task automatic run_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                             output int read_cycles);
        instr_read    = 1'b1;
        instr_address = addr;
        read_cycles   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_done) break;
            if (avm_read) read_cycles++;
        end
        check({tag, "_done"}, instr_done, 1'b1);
        check({tag, "_rdata"}, instr_readdata, exp);
        instr_read = 1'b0;
    endtask

    // Data access; call right after a negedge.
    task automatic run_data(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] exp, input logic chk_rdata);
        data_read       = rd;
        data_write      = wr;
        data_address    = addr;
        data_writedata  = wdata;
        data_byteenable = be;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_done) break;
        end
        check({tag, "_done"}, data_done, 1'b1);
        if (chk_rdata) check({tag, "_rdata"}, data_readdata, exp);
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        instr_read = 1'b0; instr_address = '0;
        data_read = 1'b0; data_write = 1'b0; data_address = '0;
        data_writedata = '0; data_byteenable = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_avm_address", avm_address, 32'h0);
        check("rst_dones", {instr_done, data_done}, 2'b00);
        check("rst_error", error, 1'b0);

        // both ports on the first cycle after reset: instruction first
        wait_cycles = 0;
        instr_read = 1'b1; instr_address = 32'hBFC0_0004;
        data_read  = 1'b1; data_address  = 32'h0000_0020; data_byteenable = 4'b1111;
        @(negedge clk);
        check("pair1_first_addr", avm_address, 32'hBFC0_0004);
        check("pair1_first_read", avm_read, 1'b1);
        @(negedge clk);
        check("pair1_instr_done", instr_done, 1'b1);
        check("pair1_instr_rdata", instr_readdata, 32'h2222_3333);
        instr_read = 1'b0;
        @(negedge clk);
        check("pair1_second_addr", avm_address, 32'h0000_0020);
        check("pair1_second_read", avm_read, 1'b1);
        @(negedge clk);
        check("pair1_data_done", data_done, 1'b1);
        check("pair1_data_rdata", data_readdata, 32'h1111_2222);
        data_read = 1'b0;
        @(negedge clk);

        // fetch with one wait state: avm_read high for two cycles
        wait_cycles = 1;
        run_fetch("fetch", 32'hBFC0_0000, 32'h3C01_1234, n);
        check("fetch_read_cycles", n, 2);
        @(negedge clk);

        // last winner was instruction, so a tie now goes to data
        wait_cycles = 0;
        instr_read = 1'b1; instr_address = 32'hBFC0_0000;
        data_read  = 1'b1; data_address  = 32'h0000_0020;
        @(negedge clk);
        check("pair2_first_addr", avm_address, 32'h0000_0020);
        @(negedge clk);
        check("pair2_data_done", data_done, 1'b1);
        data_read = 1'b0;
        @(negedge clk);
        check("pair2_second_addr", avm_address, 32'hBFC0_0000);
        @(negedge clk);
        check("pair2_instr_done", instr_done, 1'b1);
        instr_read = 1'b0;
        @(negedge clk);

        // partial store then read back
        data_write = 1'b1; data_address = 32'h10;
        data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
        @(negedge clk);
        check("store_avm_write", avm_write, 1'b1);
        check("store_avm_be", avm_byteenable, 4'b0011);
        check("store_avm_wdata", avm_writedata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("store_done", data_done, 1'b1);
        check("store_rdata_kept", data_readdata, 32'h1111_2222);
        data_write = 1'b0;
        @(negedge clk);
        run_data("load10", 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0000_BEEF, 1'b1);
        @(negedge clk);
        check("no_error_yet", error, 1'b0);

        // read and write together: write wins, error sticks
        data_read = 1'b1; data_write = 1'b1; data_address = 32'h14;
        data_writedata = 32'hCAFE_F00D; data_byteenable = 4'b1111;
        @(negedge clk);
        check("rw_avm_write", avm_write, 1'b1);
        check("rw_avm_read", avm_read, 1'b0);
        check("rw_error", error, 1'b1);
        @(negedge clk);
        check("rw_done", data_done, 1'b1);
        data_read = 1'b0; data_write = 1'b0;
        repeat (10) @(negedge clk);
        check("rw_error_sticky", error, 1'b1);
        run_data("load14", 1'b1, 1'b0, 32'h14, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b1);

        // timeout: clear error, then stall the slave
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_error", error, 1'b0);
        force_wait = 1'b1;
        instr_read = 1'b1; instr_address = 32'hBFC0_0000;
        @(negedge clk);                 // granted
        repeat (7) @(negedge clk);      // seven wait edges
        check("tmo_before", error, 1'b0);
        @(negedge clk);                 // eighth wait edge
        check("tmo_error", error, 1'b1);
        check("tmo_held_read", avm_read, 1'b1);
        force_wait = 1'b0;
        @(negedge clk);
        check("tmo_done", instr_done, 1'b1);
        check("tmo_rdata", instr_readdata, 32'h3C01_1234);
        instr_read = 1'b0;
        @(negedge clk);

        // reset in the middle of a stalled data transfer
        force_wait = 1'b1;
        data_read = 1'b1; data_address = 32'h20;
        @(negedge clk);
        check("midrst_granted", avm_read, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_avm_rw", {avm_read, avm_write}, 2'b00);
        check("midrst_dones", {instr_done, data_done}, 2'b00);
        check("midrst_error", error, 1'b0);
        check("midrst_instr_rdata", instr_readdata, 32'h0);
        reset = 1'b0; data_read = 1'b0; force_wait = 1'b0;
        @(negedge clk);
        wait_cycles = 1;
        run_fetch("post_rst_fetch", 32'hBFC0_0000, 32'h3C01_1234, n);
        check("post_rst_read_cycles", n, 2);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
